rcfwl_cdc_assert_ctrl: RTL and testbench
========================================

RCFWL_CDC_ASSERT_CTRL -- requirements
Module: rcfwl_cdc_assert_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CHK, default 8: number of checker fail inputs, range 2..64.
REQ-002 The block SHALL have parameter SETTLE_CYC, default 16: clk cycles pok must stay high before checking is enabled, range 1..255.
REQ-003 The block SHALL have parameter CNT_W, default 8: width of the failure counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be in this domain.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port pok, input, 1 bit: power-ok, active-high, asynchronous to clk.
REQ-007 The block SHALL have port chk_fail, input, NUM_CHK bits: per-checker fail pulses, synchronous to clk.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear of all failure records.
REQ-009 The block SHALL have port assert_en, output, 1 bit: global checker enable.
REQ-010 The block SHALL have port fail_sticky, output, 1 bit: a failure has been recorded since the last reset or clr.
REQ-011 The block SHALL have port first_fail_id, output, $clog2(NUM_CHK) bits: index of the first recorded failure.
REQ-012 The block SHALL have port fail_cnt, output, CNT_W bits: number of cycles with at least one recorded failure.

Function
REQ-013 pok SHALL pass through a 2-flop synchronizer to produce pok_s; no other logic SHALL sample pok directly.
REQ-014 The FSM SHALL have three states: IDLE, SETTLE and ARMED, plus an 8-bit settle counter.
REQ-015 IDLE SHALL go to SETTLE, with the counter loaded to 0, on the edge where pok_s=1.
REQ-016 SETTLE with pok_s=1 SHALL go to ARMED when counter==SETTLE_CYC-1; otherwise the counter SHALL increment by 1.
REQ-017 SETTLE or ARMED with pok_s=0 SHALL go to IDLE on the next edge and clear the counter; a pok drop mid-SETTLE restarts the full settle period.
REQ-018 assert_en SHALL equal (state==ARMED) AND pok_s, so it drops in the same cycle pok_s falls.
REQ-019 With pok held high from a quiet start, assert_en SHALL first be 1 after the (SETTLE_CYC+3)th rising clk edge that samples pok=1.
REQ-020 A cycle is a recorded failure only if assert_en=1 and chk_fail!=0; chk_fail SHALL be ignored whenever assert_en=0.
REQ-021 On a recorded failure with fail_sticky=0, fail_sticky SHALL be set to 1 and first_fail_id SHALL capture the lowest set index of chk_fail in that cycle.
REQ-022 On a recorded failure with fail_sticky=1, first_fail_id SHALL hold its value.
REQ-023 fail_cnt SHALL increment by exactly 1 per recorded-failure cycle, regardless of how many chk_fail bits are set.
REQ-024 fail_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 clr=1 SHALL zero fail_sticky, first_fail_id and fail_cnt on the next edge; clr SHALL take priority, and a failure in the same cycle SHALL be dropped.
REQ-026 clr SHALL NOT affect the FSM or assert_en.
REQ-027 All outputs SHALL be glitch-free registered values, except assert_en per REQ-018.

Reset
REQ-028 While rst=1, the synchronizer flops SHALL be 0, state SHALL be IDLE and the counter SHALL be 0.
REQ-029 While rst=1, assert_en, fail_sticky, first_fail_id and fail_cnt SHALL all be 0.
REQ-030 rst asserted mid-SETTLE or mid-ARMED SHALL immediately force the REQ-028/029 values, and the full settle sequence SHALL restart after release.
REQ-031 Records SHALL survive pok loss; only rst or clr SHALL clear them.

Verification
REQ-032 Bench SHALL cover pok rise, SETTLE_CYC=16 -> assert_en=1 on edge 19 and held while pok=1.
REQ-033 Bench SHALL cover pok low for 2 cycles at SETTLE count 10 -> return to IDLE, then a full 16-cycle settle after pok_s re-rises.
REQ-034 Bench SHALL cover chk_fail=8'b0010_1000 while ARMED -> fail_sticky=1, first_fail_id=3, fail_cnt=1; a later chk_fail=8'b0000_0001 -> id stays 3, cnt=2.
REQ-035 Bench SHALL cover chk_fail=8'hFF during SETTLE and while pok_s=0 -> no record, all outputs stay 0.
REQ-036 Bench SHALL cover CNT_W=2 with 5 failure cycles -> fail_cnt=3; then clr together with a fail -> all records 0.
REQ-037 Bench SHALL cover rst pulse while ARMED with fail_sticky=1 -> all outputs 0 immediately, and assert_en=1 again 19 edges after release with pok high.

Source files
------------

// File: rtl/rcfwl_cdc_assert_ctrl.sv
// Power-ok gated checker enable with sticky failure capture; pok to assert_en is SETTLE_CYC+3 clk edges.
// Records register one edge after a failing cycle; there is no backpressure, and chk_fail is ignored unless assert_en is high.
module rcfwl_cdc_assert_ctrl #(
  parameter int NUM_CHK    = 8,
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 8,
  localparam int ID_W      = $clog2(NUM_CHK)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pok,
  input  logic [NUM_CHK-1:0] chk_fail,
  input  logic               clr,
  output logic               assert_en,
  output logic               fail_sticky,
  output logic [ID_W-1:0]    first_fail_id,
  output logic [CNT_W-1:0]   fail_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] ARMED  = 2'd2;

  logic       pok_meta;
  logic       pok_s;
  logic [1:0] state;
  logic [7:0] settle_cnt;
  logic       rec_fail;
  logic [ID_W-1:0] low_id;

  // pok is asynchronous; only pok_s may be used downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pok_meta <= 1'b0;
      pok_s    <= 1'b0;
    end else begin
      pok_meta <= pok;
      pok_s    <= pok_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= 8'd0;
    end else if (!pok_s) begin
      state      <= IDLE;
      settle_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          state      <= SETTLE;
          settle_cnt <= 8'd0;
        end
        SETTLE: begin
          if (settle_cnt == 8'(SETTLE_CYC - 1)) begin
            state <= ARMED;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        ARMED: state <= ARMED;
        default: begin
          state      <= IDLE;
          settle_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Gated by pok_s so the enable falls in the same cycle pok_s does
  assign assert_en = (state == ARMED) && pok_s;
  assign rec_fail  = assert_en && (|chk_fail);

  always_comb begin
    low_id = '0;
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      if (chk_fail[i]) low_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_sticky   <= 1'b0;
      first_fail_id <= '0;
      fail_cnt      <= '0;
    end else if (clr) begin
      fail_sticky   <= 1'b0;
      first_fail_id <= '0;
      fail_cnt      <= '0;
    end else if (rec_fail) begin
      fail_sticky <= 1'b1;
      if (!fail_sticky) first_fail_id <= low_id;
      if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rcfwl_cdc_assert_ctrl.sv
// Directed bench: settle timing, pok drop restart, failure capture, saturation, clr and rst.
module tb_rcfwl_cdc_assert_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pok;
  logic [7:0] chk_fail, chk_fail2;
  logic       clr, clr2;
  logic       assert_en, assert_en2;
  logic       fail_sticky, fail_sticky2;
  logic [2:0] first_fail_id, first_fail_id2;
  logic [7:0] fail_cnt;
  logic [1:0] fail_cnt2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rcfwl_cdc_assert_ctrl #(.NUM_CHK(8), .SETTLE_CYC(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .pok(pok), .chk_fail(chk_fail), .clr(clr),
    .assert_en(assert_en), .fail_sticky(fail_sticky),
    .first_fail_id(first_fail_id), .fail_cnt(fail_cnt)
  );

  rcfwl_cdc_assert_ctrl #(.NUM_CHK(8), .SETTLE_CYC(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .pok(pok), .chk_fail(chk_fail2), .clr(clr2),
    .assert_en(assert_en2), .fail_sticky(fail_sticky2),
    .first_fail_id(first_fail_id2), .fail_cnt(fail_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_recs_zero(input string tag);
    chk({tag, "_en"},  {31'd0, assert_en},   32'd0);
    chk({tag, "_stk"}, {31'd0, fail_sticky}, 32'd0);
    chk({tag, "_id"},  {29'd0, first_fail_id}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, fail_cnt},    32'd0);
  endtask

  initial begin
    rst = 1'b1; pok = 1'b0; chk_fail = 8'h00; chk_fail2 = 8'h00; clr = 1'b0; clr2 = 1'b0;
    tick(3);
    chk_recs_zero("reset");
    rst = 1'b0;
    tick(2);

    // pok rise: enable expected exactly after edge 19; chk_fail=FF during settle must not record
    pok = 1'b1;
    chk_fail = 8'hFF;
    for (int n = 1; n <= 19; n++) begin
      tick();
      if (n == 18) chk_fail = 8'h00;
      chk($sformatf("rise_e%0d", n), {31'd0, assert_en}, (n >= 19) ? 32'd1 : 32'd0);
    end
    chk("settle_ff_stk", {31'd0, fail_sticky}, 32'd0);
    chk("settle_ff_cnt", {24'd0, fail_cnt}, 32'd0);
    tick(5);
    chk("armed_hold", {31'd0, assert_en}, 32'd1);

    // pok drop: enable falls after two synchronizer edges; chk_fail ignored while low
    pok = 1'b0;
    tick();
    chk("drop_e1", {31'd0, assert_en}, 32'd1);
    tick();
    chk("drop_e2", {31'd0, assert_en}, 32'd0);
    chk_fail = 8'hFF;
    tick(4);
    chk_fail = 8'h00;
    tick();
    chk_recs_zero("pok_low_ff");

    // re-rise, drop for 2 cycles at settle count 10, full settle after pok_s re-rises
    pok = 1'b1;
    tick(13);
    pok = 1'b0;
    tick(2);
    pok = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      tick();
      chk($sformatf("restart_e%0d", n), {31'd0, assert_en}, (n >= 19) ? 32'd1 : 32'd0);
    end

    // failure capture on the default instance
    chk_fail = 8'b0010_1000;
    tick();
    chk_fail = 8'h00;
    chk("f1_stk", {31'd0, fail_sticky}, 32'd1);
    chk("f1_id",  {29'd0, first_fail_id}, 32'd3);
    chk("f1_cnt", {24'd0, fail_cnt}, 32'd1);
    tick(2);
    chk_fail = 8'b0000_0001;
    tick();
    chk_fail = 8'h00;
    chk("f2_id",  {29'd0, first_fail_id}, 32'd3);
    chk("f2_cnt", {24'd0, fail_cnt}, 32'd2);

    // 2-bit counter saturates at 3, then clr wins over a same-cycle failure
    chk_fail2 = 8'h01;
    tick(5);
    chk_fail2 = 8'h00;
    chk("sat_cnt", {30'd0, fail_cnt2}, 32'd3);
    chk("sat_id",  {29'd0, first_fail_id2}, 32'd0);
    chk_fail2 = 8'h10;
    clr2 = 1'b1;
    tick();
    chk_fail2 = 8'h00;
    clr2 = 1'b0;
    chk("clr_stk", {31'd0, fail_sticky2}, 32'd0);
    chk("clr_id",  {29'd0, first_fail_id2}, 32'd0);
    chk("clr_cnt", {30'd0, fail_cnt2}, 32'd0);
    chk("clr_en",  {31'd0, assert_en2}, 32'd1);

    // records survive pok loss
    pok = 1'b0;
    tick(5);
    chk("keep_en",  {31'd0, assert_en}, 32'd0);
    chk("keep_stk", {31'd0, fail_sticky}, 32'd1);
    chk("keep_id",  {29'd0, first_fail_id}, 32'd3);
    chk("keep_cnt", {24'd0, fail_cnt}, 32'd2);
    pok = 1'b1;
    tick(19);
    chk("rearm_en", {31'd0, assert_en}, 32'd1);

    // asynchronous rst while armed with a sticky record
    rst = 1'b1;
    #1;
    chk_recs_zero("rst_async");
    tick(2);
    rst = 1'b0;
    for (int n = 1; n <= 19; n++) begin
      tick();
      chk($sformatf("post_rst_e%0d", n), {31'd0, assert_en}, (n >= 19) ? 32'd1 : 32'd0);
    end
    chk("post_rst_stk", {31'd0, fail_sticky}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
